// File: rtl/puf_majority_voter.sv
// rtl/puf_majority_voter.sv - majority-votes NUM_EVAL PUF responses into one key word
// Optional feature macro: PUF_STABILITY_EN (adds unstable_mask output).
module puf_majority_voter #(
  parameter int RESP_W   = 8,
  parameter int NUM_EVAL = 5,
  parameter int TIMEOUT  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [RESP_W-1:0] resp_in,
  input  logic              resp_ready,
  output logic              buf_clear,
  output logic [RESP_W-1:0] key,
  output logic              key_valid,
  input  logic              key_ack,
  output logic              busy,
`ifdef PUF_STABILITY_EN
  output logic [RESP_W-1:0] unstable_mask,
`endif
  output logic              err
);
  localparam int CW = $clog2(NUM_EVAL + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] HALF   = CW'(NUM_EVAL / 2);
  localparam logic [CW-1:0] LAST   = CW'(NUM_EVAL - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WAIT, S_ACCUM, S_DONE} state_t;

  state_t            state;
  logic [CW-1:0]     vote      [RESP_W];
  logic [CW-1:0]     vote_next [RESP_W];
  logic [CW-1:0]     eval_cnt;
  logic [TW-1:0]     timer;
  logic              ready_q;
  logic [RESP_W-1:0] cap;
  logic [RESP_W-1:0] key_next;
`ifdef PUF_STABILITY_EN
  localparam logic [CW-1:0] FULL = CW'(NUM_EVAL);
  logic [RESP_W-1:0] mask_next;
`endif

  // Key is decided from the tallies including the final capture, so DONE entry
  // can register it in the same edge that closes the last ACCUM.
  always_comb begin
    for (int i = 0; i < RESP_W; i++) begin
      vote_next[i] = vote[i] + CW'(cap[i]);
      key_next[i]  = (vote_next[i] > HALF);
    end
  end

`ifdef PUF_STABILITY_EN
  always_comb begin
    for (int i = 0; i < RESP_W; i++) begin
      mask_next[i] = (vote_next[i] != '0) && (vote_next[i] != FULL);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      buf_clear <= 1'b0;
      key       <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      eval_cnt  <= '0;
      timer     <= '0;
      ready_q   <= 1'b0;
      cap       <= '0;
      for (int i = 0; i < RESP_W; i++) vote[i] <= '0;
`ifdef PUF_STABILITY_EN
      unstable_mask <= '0;
`endif
    end else begin
      ready_q <= resp_ready;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_CLEAR;
            buf_clear <= 1'b1;
            busy      <= 1'b1;
            err       <= 1'b0;
            eval_cnt  <= '0;
            for (int i = 0; i < RESP_W; i++) vote[i] <= '0;
          end
        end
        S_CLEAR: begin
          buf_clear <= 1'b0;
          timer     <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // Only a fresh rising edge counts; a ready left high across CLEAR is stale.
          if (resp_ready && !ready_q) begin
            cap   <= resp_in;
            state <= S_ACCUM;
          end else if (timer == T_LAST) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            err       <= 1'b1;
            key_valid <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_ACCUM: begin
          for (int i = 0; i < RESP_W; i++) vote[i] <= vote_next[i];
          eval_cnt <= eval_cnt + CW'(1);
          if (eval_cnt == LAST) begin
            state     <= S_DONE;
            key       <= key_next;
            key_valid <= 1'b1;
`ifdef PUF_STABILITY_EN
            unstable_mask <= mask_next;
`endif
          end else begin
            state     <= S_CLEAR;
            buf_clear <= 1'b1;
          end
        end
        S_DONE: begin
          if (key_ack) begin
            key_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          buf_clear <= 1'b0;
          key_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_puf_majority_voter.sv
// tb/tb_puf_majority_voter.sv - table-driven and randomized bench for puf_majority_voter
module tb_puf_majority_voter;
  localparam int W  = 8;
  localparam int NE = 5;
  localparam int TO = 64;
  localparam int NONE = 15;

  typedef logic [NE-1:0][W-1:0] resp_set_t;
  typedef struct packed {
    resp_set_t  r;
    logic [W-1:0] k;
    logic [W-1:0] m;
    logic [3:0] stale;
    logic [3:0] sw;
    logic [4:0] hold;
    logic       sdone;
    logic       sack;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         resp_ready = 1'b0;
  logic         key_ack = 1'b0;
  logic [W-1:0] resp_in = '0;
  logic         buf_clear, key_valid, busy, err;
  logic [W-1:0] key;
`ifdef PUF_STABILITY_EN
  logic [W-1:0] unstable_mask;
`endif

  int checks = 0;
  int failures = 0;
  vec_t vecs [6];

  always #5 clk = ~clk;

  puf_majority_voter #(.RESP_W(W), .NUM_EVAL(NE), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .resp_in(resp_in),
    .resp_ready(resp_ready), .buf_clear(buf_clear), .key(key),
    .key_valid(key_valid), .key_ack(key_ack), .busy(busy),
`ifdef PUF_STABILITY_EN
    .unstable_mask(unstable_mask),
`endif
    .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic resp_set_t mk(input logic [W-1:0] a, b, c, d, e);
    resp_set_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e;
    return r;
  endfunction

  // Reference: count ones per bit position across all evaluations.
  function automatic logic [W-1:0] ref_key(input resp_set_t r);
    logic [W-1:0] k;
    for (int b = 0; b < W; b++) begin
      int ones = 0;
      for (int e = 0; e < NE; e++) ones += int'(r[e][b]);
      k[b] = (2 * ones > NE);
    end
    return k;
  endfunction

  function automatic logic [W-1:0] ref_mask(input resp_set_t r);
    logic [W-1:0] m;
    for (int b = 0; b < W; b++) begin
      int ones = 0;
      for (int e = 0; e < NE; e++) ones += int'(r[e][b]);
      m[b] = (ones > 0) && (ones < NE);
    end
    return m;
  endfunction

  function automatic logic [31:0] outs_now();
`ifdef PUF_STABILITY_EN
    return {13'd0, unstable_mask, buf_clear, key, key_valid, busy, err};
`else
    return {21'd0, buf_clear, key, key_valid, busy, err};
`endif
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; key_ack = 1'b0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Acts as the response buffer: reacts to each buf_clear, then presents a response.
  task automatic run_evals(input resp_set_t r, input int fill, input int stale, input int sw,
                           input int abort_eval, input int timeout_eval, output bit reached);
    int n;
    int bc_bad;
    reached = 1'b0;
    bc_bad = 0;
    resp_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_clear_on_start", err, 0);
    for (int e = 0; e < NE; e++) begin
      n = 0;
      while (!buf_clear && n < 200) begin @(negedge clk); n++; end
      if (!buf_clear) begin
        check("buf_clear_wait_bound", 0, 1);
        return;
      end
      if (e == timeout_eval) begin
        resp_ready = 1'b0;
        n = 0;
        while (!err && n < 100) begin @(negedge clk); n++; end
        check("timeout_cycles", n, TO + 1);
        check("timeout_busy", busy, 0);
        check("timeout_key_valid", key_valid, 0);
        return;
      end
      if (e == stale) begin
        resp_ready = 1'b1;
        resp_in = ~r[e];
      end else begin
        resp_ready = 1'b0;
      end
      for (int c = 0; c < ((e == stale) ? 10 : fill); c++) begin
        start = (e == sw && c == 0);
        @(negedge clk);
        if (buf_clear || key_valid) bc_bad++;
      end
      start = 1'b0;
      if (e == stale) begin
        resp_ready = 1'b0;
        @(negedge clk);
      end
      resp_in = r[e];
      resp_ready = 1'b1;
      if (e == abort_eval) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", outs_now(), 0);
        @(negedge clk);
        resp_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        return;
      end
    end
    n = 0;
    while (!key_valid && n < 50) begin @(negedge clk); n++; end
    check("buf_clear_single_cycle", bc_bad, 0);
    reached = key_valid;
  endtask

  task automatic finish_key(input logic [W-1:0] ek, input logic [W-1:0] em, input int hold,
                            input bit sdone, input bit sack);
    int bad;
    check("key_value", key, ek);
    check("key_valid_set", key_valid, 1);
`ifdef PUF_STABILITY_EN
    check("unstable_mask", unstable_mask, em);
`else
    if (em !== em) check("mask_unused", 0, 1);
`endif
    bad = 0;
    for (int c = 0; c < hold; c++) begin
      start = sdone && (c == 0);
      @(negedge clk);
      if (!key_valid || key !== ek || !busy || buf_clear) bad++;
    end
    start = 1'b0;
    if (hold > 0) check("hold_without_ack", bad, 0);
    key_ack = 1'b1;
    start = sack;
    @(negedge clk);
    key_ack = 1'b0;
    start = 1'b0;
    check("ack_clears_valid", key_valid, 0);
    check("ack_to_idle", busy, 0);
    check("key_held_after_ack", key, ek);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy || buf_clear) bad++;
    end
    check("idle_after_ack", bad, 0);
  endtask

  initial begin
    bit ok;
    resp_set_t rr;
    vecs[0] = '{r: mk(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5), k: 8'hA5, m: 8'h00,
                stale: 4'(NONE), sw: 4'(NONE), hold: 5'd0, sdone: 1'b0, sack: 1'b0};
    vecs[1] = '{r: mk(8'hA5, 8'hA5, 8'h5A, 8'hA5, 8'h5A), k: 8'hA5, m: 8'hFF,
                stale: 4'(NONE), sw: 4'(NONE), hold: 5'd10, sdone: 1'b0, sack: 1'b0};
    vecs[2] = '{r: mk(8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF), k: 8'hFF, m: 8'hFF,
                stale: 4'(NONE), sw: 4'd1, hold: 5'd3, sdone: 1'b1, sack: 1'b0};
    vecs[3] = '{r: mk(8'h0F, 8'h0F, 8'hF0, 8'h33, 8'h00), k: 8'h03, m: 8'hFF,
                stale: 4'(NONE), sw: 4'(NONE), hold: 5'd0, sdone: 1'b0, sack: 1'b1};
    vecs[4] = '{r: mk(8'h81, 8'h81, 8'h81, 8'h81, 8'h81), k: 8'h81, m: 8'h00,
                stale: 4'd2, sw: 4'(NONE), hold: 5'd0, sdone: 1'b0, sack: 1'b0};
    vecs[5] = '{r: mk(8'hFE, 8'hFF, 8'h7F, 8'hFF, 8'hFF), k: 8'hFF, m: 8'h81,
                stale: 4'(NONE), sw: 4'(NONE), hold: 5'd0, sdone: 1'b0, sack: 1'b0};

    repeat (3) @(negedge clk);
    check("reset_outputs", outs_now(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    check("ack_in_idle_ignored", {busy, key_valid}, 0);

    for (int i = 0; i < 6; i++) begin
      run_evals(vecs[i].r, 3, int'(vecs[i].stale), int'(vecs[i].sw), NONE, NONE, ok);
      check("done_reached", ok, 1);
      if (ok) finish_key(vecs[i].k, vecs[i].m, int'(vecs[i].hold), vecs[i].sdone, vecs[i].sack);
      else do_reset();
    end

    run_evals(vecs[0].r, 3, NONE, NONE, NONE, 2, ok);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    check("err_sticky", err, 1);
    check("ack_after_err_ignored", {busy, key_valid}, 0);
    run_evals(vecs[5].r, 4, NONE, NONE, NONE, NONE, ok);
    check("run_after_timeout", ok, 1);
    if (ok) finish_key(vecs[5].k, vecs[5].m, 0, 1'b0, 1'b0);
    else do_reset();

    run_evals(vecs[1].r, 3, NONE, NONE, 2, NONE, ok);
    run_evals(vecs[1].r, 3, NONE, NONE, NONE, NONE, ok);
    check("run_after_reset", ok, 1);
    if (ok) finish_key(vecs[1].k, vecs[1].m, 0, 1'b0, 1'b0);
    else do_reset();

    for (int t = 0; t < 8; t++) begin
      for (int e = 0; e < NE; e++) rr[e] = 8'($urandom());
      run_evals(rr, int'($urandom_range(2, 6)), NONE, NONE, NONE, NONE, ok);
      check("rand_done_reached", ok, 1);
      if (ok) finish_key(ref_key(rr), ref_mask(rr), 0, 1'b0, 1'b0);
      else do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
